// File: rtl/tqvp_tacos_mc.sv
// Multi-channel prescaled count/compare peripheral for the TinyQV bus.
// Each channel has a 4-register window: CTRL, PRESCALE, COMPARE, COUNT.
module tqvp_tacos_mc #(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    // Bus handshake: a read request (data_read_n != 11) is captured on the clock edge
    // that samples it; data_out is then valid while data_ready is high for exactly one
    // clock. Writes (data_write_n != 11) complete on the sampling edge with no response.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } ch_state_e;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_COMPARE  = 2'd2;
    localparam logic [1:0] REG_COUNT    = 2'd3;

    logic [2:0]  sel_ch;
    logic [1:0]  sel_reg;
    logic        mapped;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] wr_mask;
    logic [31:0] rd_data;
    logic        unused_ui;

    logic [31:0]       rd_ctrl [NUM_CH];
    logic [31:0]       rd_psc  [NUM_CH];
    logic [31:0]       rd_cmp  [NUM_CH];
    logic [31:0]       rd_cnt  [NUM_CH];
    logic [NUM_CH-1:0] irq_vec;
    logic [NUM_CH-1:0] tog_vec;

    assign sel_ch    = address[4:2];
    assign sel_reg   = address[1:0];
    assign mapped    = !address[5] && ({1'b0, sel_ch} < 4'(NUM_CH));
    assign wr_req    = (data_write_n != 2'b11) && mapped;
    assign rd_req    = (data_read_n != 2'b11);
    assign unused_ui = ^ui_in;

    always_comb begin
        case (data_write_n)
            2'b00:   wr_mask = 32'h0000_00ff;
            2'b01:   wr_mask = 32'h0000_ffff;
            2'b10:   wr_mask = 32'hffff_ffff;
            default: wr_mask = 32'h0000_0000;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_e          state_q, state_d;
        logic               auto_q, auto_d;
        logic               irq_en_q, irq_en_d;
        logic               out_en_q, out_en_d;
        logic               ext_q, ext_d;
        logic               flag_q, flag_d;
        logic               tog_q, tog_d;
        logic [COUNT_W-1:0] psc_q, psc_d;
        logic [COUNT_W-1:0] cmp_q, cmp_d;
        logic [COUNT_W-1:0] cnt_q, cnt_d;
        logic [COUNT_W-1:0] div_q, div_d;
        logic [2:0]         sync_q;
        logic               wr_hit;
        logic               tick;
        logic               match;
        logic               running;

        assign wr_hit  = wr_req && (sel_ch == 3'(c));
        assign running = (state_q == S_RUN);
        // sync_q[1] is the synchronised input, sync_q[2] its previous value
        assign tick    = running && (ext_q ? (sync_q[1] && !sync_q[2]) : (div_q == psc_q));
        assign match   = tick && (cnt_q == cmp_q);

        always_comb begin
            state_d  = state_q;
            auto_d   = auto_q;
            irq_en_d = irq_en_q;
            out_en_d = out_en_q;
            ext_d    = ext_q;
            flag_d   = flag_q;
            tog_d    = tog_q;
            psc_d    = psc_q;
            cmp_d    = cmp_q;
            cnt_d    = cnt_q;
            div_d    = div_q;

            if (running && !ext_q) begin
                div_d = tick ? '0 : div_q + COUNT_W'(1);
            end

            if (tick) begin
                if (match) begin
                    if (out_en_q) tog_d = !tog_q;
                    if (auto_q) cnt_d = '0;
                    else        state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + COUNT_W'(1);
                end
            end

            if (wr_hit) begin
                case (sel_reg)
                    REG_CTRL: begin
                        auto_d   = data_in[1];
                        irq_en_d = data_in[2];
                        out_en_d = data_in[3];
                        ext_d    = data_in[5];
                        if (data_in[4]) flag_d = 1'b0;
                        if (!data_in[0]) begin
                            state_d = S_IDLE;
                        end else if (!running) begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            div_d   = '0;
                        end
                    end
                    REG_PRESCALE: psc_d = (psc_q & ~wr_mask[COUNT_W-1:0])
                                        | (data_in[COUNT_W-1:0] & wr_mask[COUNT_W-1:0]);
                    REG_COMPARE:  cmp_d = (cmp_q & ~wr_mask[COUNT_W-1:0])
                                        | (data_in[COUNT_W-1:0] & wr_mask[COUNT_W-1:0]);
                    default: ;
                endcase
            end

            // A match in the same cycle as a clear request keeps the flag set
            if (match) flag_d = 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= S_IDLE;
                auto_q   <= 1'b0;
                irq_en_q <= 1'b0;
                out_en_q <= 1'b0;
                ext_q    <= 1'b0;
                flag_q   <= 1'b0;
                tog_q    <= 1'b0;
                psc_q    <= '0;
                cmp_q    <= '0;
                cnt_q    <= '0;
                div_q    <= '0;
                sync_q   <= '0;
            end else begin
                state_q  <= state_d;
                auto_q   <= auto_d;
                irq_en_q <= irq_en_d;
                out_en_q <= out_en_d;
                ext_q    <= ext_d;
                flag_q   <= flag_d;
                tog_q    <= tog_d;
                psc_q    <= psc_d;
                cmp_q    <= cmp_d;
                cnt_q    <= cnt_d;
                div_q    <= div_d;
                sync_q   <= {sync_q[1:0], ui_in[c]};
            end
        end

        assign rd_ctrl[c] = {14'b0, running, flag_q, 10'b0, ext_q, 1'b0,
                             out_en_q, irq_en_q, auto_q, running};
        assign rd_psc[c]  = 32'(psc_q);
        assign rd_cmp[c]  = 32'(cmp_q);
        assign rd_cnt[c]  = 32'(cnt_q);
        assign irq_vec[c] = flag_q && irq_en_q;
        assign tog_vec[c] = tog_q;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mapped && (sel_ch == 3'(i))) begin
                case (sel_reg)
                    REG_CTRL:     rd_data = rd_ctrl[i];
                    REG_PRESCALE: rd_data = rd_psc[i];
                    REG_COMPARE:  rd_data = rd_cmp[i];
                    REG_COUNT:    rd_data = rd_cnt[i];
                    default:      rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_ready     <= 1'b0;
            user_interrupt <= 1'b0;
        end else begin
            data_ready     <= rd_req;
            if (rd_req) data_out <= rd_data;
            user_interrupt <= |irq_vec;
        end
    end

    assign uo_out = 8'(tog_vec);

endmodule

// File: tb/tb_tqvp_tacos_mc.sv
// Bench for tqvp_tacos_mc: cycle-level register/timer model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tqvp_tacos_mc;

    localparam int NCH = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int n_checks = 0;
    int n_errors = 0;

    tqvp_tacos_mc #(.NUM_CH(NCH), .COUNT_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_en    [NCH];
    bit          m_auto  [NCH];
    bit          m_irqen [NCH];
    bit          m_outen [NCH];
    bit          m_ext   [NCH];
    bit          m_flag  [NCH];
    bit          m_tog   [NCH];
    logic [31:0] m_psc   [NCH];
    logic [31:0] m_cmp   [NCH];
    logic [31:0] m_cnt   [NCH];
    logic [31:0] m_div   [NCH];
    logic [7:0]  ui_s1, ui_s2, ui_s3;
    logic [31:0] exp_data;
    bit          exp_ready;
    bit          exp_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int ch;
        logic [31:0] v;
        ch = int'(a[4:2]);
        v = 32'h0;
        if (a[5] || ch >= NCH) return 32'h0;
        case (a[1:0])
            2'd0: begin
                if (m_en[ch])    v = v | 32'h0002_0001;
                if (m_flag[ch])  v = v | 32'h0001_0000;
                if (m_auto[ch])  v = v | 32'h0000_0002;
                if (m_irqen[ch]) v = v | 32'h0000_0004;
                if (m_outen[ch]) v = v | 32'h0000_0008;
                if (m_ext[ch])   v = v | 32'h0000_0020;
            end
            2'd1: v = m_psc[ch];
            2'd2: v = m_cmp[ch];
            default: v = m_cnt[ch];
        endcase
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz);
        case (sz)
            2'b00:   return {old[31:8], wd[7:0]};
            2'b01:   return {old[31:16], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_auto[c] = 0; m_irqen[c] = 0; m_outen[c] = 0;
            m_ext[c] = 0; m_flag[c] = 0; m_tog[c] = 0;
            m_psc[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0; m_div[c] = 0;
        end
        ui_s1 = 0; ui_s2 = 0; ui_s3 = 0;
        exp_data = 0; exp_ready = 0; exp_irq = 0;
    endtask

    task automatic model_step();
        bit matched [NCH];
        bit was_en  [NCH];
        bit tick;
        int ch;
        exp_irq = 0;
        for (int c = 0; c < NCH; c++) if (m_flag[c] && m_irqen[c]) exp_irq = 1;
        if (data_read_n != 2'b11) begin
            exp_data  = model_read(address);
            exp_ready = 1;
        end else begin
            exp_ready = 0;
        end
        for (int c = 0; c < NCH; c++) begin
            was_en[c]  = m_en[c];
            matched[c] = 0;
            tick = 0;
            if (m_en[c]) begin
                if (m_ext[c]) tick = ui_s2[c] && !ui_s3[c];
                else if (m_div[c] == m_psc[c]) begin tick = 1; m_div[c] = 0; end
                else m_div[c] = m_div[c] + 1;
            end
            if (tick) begin
                if (m_cnt[c] == m_cmp[c]) begin
                    matched[c] = 1;
                    if (m_outen[c]) m_tog[c] = !m_tog[c];
                    if (m_auto[c]) m_cnt[c] = 0;
                    else m_en[c] = 0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
        end
        if (data_write_n != 2'b11 && !address[5] && int'(address[4:2]) < NCH) begin
            ch = int'(address[4:2]);
            case (address[1:0])
                2'd0: begin
                    m_auto[ch]  = data_in[1];
                    m_irqen[ch] = data_in[2];
                    m_outen[ch] = data_in[3];
                    m_ext[ch]   = data_in[5];
                    if (data_in[4]) m_flag[ch] = 0;
                    if (!data_in[0]) m_en[ch] = 0;
                    else if (!was_en[ch]) begin
                        m_en[ch] = 1; m_cnt[ch] = 0; m_div[ch] = 0;
                    end
                end
                2'd1: m_psc[ch] = merge(m_psc[ch], data_in, data_write_n);
                2'd2: m_cmp[ch] = merge(m_cmp[ch], data_in, data_write_n);
                default: ;
            endcase
        end
        for (int c = 0; c < NCH; c++) if (matched[c]) m_flag[c] = 1;
        ui_s3 = ui_s2; ui_s2 = ui_s1; ui_s1 = ui_in;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [7:0] exp_uo;
        exp_uo = 8'h00;
        for (int c = 0; c < NCH; c++) exp_uo[c] = m_tog[c];
        check("uo_out", {24'h0, uo_out}, {24'h0, exp_uo});
        check("user_interrupt", {31'h0, user_interrupt}, {31'h0, exp_irq});
        check("data_ready", {31'h0, data_ready}, {31'h0, exp_ready});
        if (exp_ready) check("data_out", data_out, exp_data);
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        address = a; data_in = d; data_write_n = sz;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d);
        address = a; data_read_n = 2'b10;
        @(negedge clk);
        d = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic wait_uo(input int ch, input logic want, output int cyc);
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (uo_out[ch] === want) begin cyc = k; break; end
        end
        if (cyc == 0) begin
            n_checks++; n_errors++;
            $display("FAIL wait_uo: uo_out[%0d] never reached %0b within 200 clocks", ch, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] d;
        int cyc;
        rst_n = 1'b1; ui_in = 8'h00; address = 6'h00; data_in = 32'h0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("rst_uo_out", {24'h0, uo_out}, 32'h0);
        check("rst_irq", {31'h0, user_interrupt}, 32'h0);
        check("rst_data_ready", {31'h0, data_ready}, 32'h0);
        check("rst_data_out", data_out, 32'h0);
        for (int r = 0; r < 4; r++) begin
            do_read(6'(r), d);
            check("rst_read_ch0", d, 32'h0);
        end

        // ch0: tick every 4 clocks, match on 5th tick -> 20 clocks per toggle
        do_write(6'h01, 32'd3, 2'b10);
        do_write(6'h02, 32'd4, 2'b10);
        do_write(6'h00, 32'h0F, 2'b10);
        wait_uo(0, 1'b1, cyc);
        check("ch0_first_toggle_clks", 32'(cyc), 32'd20);
        wait_uo(0, 1'b0, cyc);
        check("ch0_period_clks", 32'(cyc), 32'd20);
        do_read(6'h00, d);
        check("ch0_ctrl_flag", d, 32'h0003_000F);
        do_write(6'h00, 32'h10, 2'b10);

        // ch1 one-shot
        do_write(6'h05, 32'd0, 2'b10);
        do_write(6'h06, 32'd2, 2'b10);
        do_write(6'h04, 32'h05, 2'b10);
        repeat (10) @(negedge clk);
        do_read(6'h04, d);
        check("ch1_oneshot_ctrl", d, 32'h0001_0004);
        do_read(6'h07, d);
        check("ch1_oneshot_count", d, 32'd2);
        check("ch1_oneshot_irq", {31'h0, user_interrupt}, 32'h1);
        do_write(6'h04, 32'h10, 2'b10);

        // partial writes, read-only COUNT, unmapped addresses
        do_write(6'h0A, 32'h1122_3344, 2'b10);
        do_write(6'h0A, 32'hBEEF_DEAD, 2'b01);
        do_read(6'h0A, d);
        check("ch2_half_write", d, 32'h1122_DEAD);
        do_write(6'h0A, 32'h0000_0077, 2'b00);
        do_read(6'h0A, d);
        check("ch2_byte_write", d, 32'h1122_DE77);
        do_write(6'h0B, 32'h55, 2'b10);
        do_read(6'h0B, d);
        check("ch2_count_ro", d, 32'h0);
        do_write(6'h20, 32'h0F, 2'b10);
        do_write(6'h10, 32'h0F, 2'b10);
        do_write(6'h3C, 32'hFFFF, 2'b10);
        do_read(6'h00, d);
        check("unmapped_wr_ch0", d, 32'h0);
        do_read(6'h10, d);
        check("unmapped_rd_ch4", d, 32'h0);
        do_read(6'h2A, d);
        check("unmapped_rd_a5", d, 32'h0);

        // ch3 external tick, auto-reload
        do_write(6'h0E, 32'd1, 2'b10);
        do_write(6'h0C, 32'h2F, 2'b10);
        for (int p = 0; p < 2; p++) begin
            ui_in[3] = 1'b1;
            repeat (3) @(negedge clk);
            ui_in[3] = 1'b0;
            repeat (3) @(negedge clk);
            do_read(6'h0C, d);
            check("ch3_ext_ctrl", d, (p == 0) ? 32'h0002_002F : 32'h0003_002F);
        end
        do_read(6'h0F, d);
        check("ch3_ext_count", d, 32'h0);
        check("ch3_ext_uo", {31'h0, uo_out[3]}, 32'h1);
        check("ch3_ext_irq", {31'h0, user_interrupt}, 32'h1);
        do_write(6'h0C, 32'h10, 2'b10);

        // ch1 clear request lands on the second match (6th clock after enable)
        do_write(6'h04, 32'h07, 2'b10);
        repeat (5) @(negedge clk);
        do_write(6'h04, 32'h17, 2'b10);
        do_read(6'h04, d);
        check("ch1_set_wins", d, 32'h0003_0007);
        do_write(6'h04, 32'h10, 2'b10);

        // asynchronous reset mid-run
        do_write(6'h00, 32'h0F, 2'b10);
        repeat (25) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_uo_out", {24'h0, uo_out}, 32'h0);
        check("mid_rst_irq", {31'h0, user_interrupt}, 32'h0);
        check("mid_rst_data_out", data_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(6'h00, d);
        check("post_rst_ctrl", d, 32'h0);
        do_read(6'h02, d);
        check("post_rst_compare", d, 32'h0);
        do_write(6'h01, 32'd3, 2'b10);
        do_write(6'h02, 32'd4, 2'b10);
        do_write(6'h00, 32'h0F, 2'b10);
        wait_uo(0, 1'b1, cyc);
        check("post_rst_toggle_clks", 32'(cyc), 32'd20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
